// File: rtl/zigzag_decryption_n.sv
// rtl/zigzag_decryption_n.sv - N-rail zigzag (rail-fence) decryption engine
// Buffers ciphertext until the start token, then counts rail lengths, builds rail offsets and emits plaintext.
module zigzag_decryption_n #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter int                 MAX_KEY                = 8,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy,
  output logic                 err_o
);
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int RW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
  localparam logic [CW-1:0]        MAX_N = CW'(MAX_NOF_CHARS);
  localparam logic [KEY_WIDTH-1:0] MAX_K = KEY_WIDTH'(MAX_KEY);

  typedef enum logic [1:0] {LOAD, COUNT, OFFS, OUT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          n_q, n_d, p_q, p_d;
  logic                   ovf_q, ovf_d, dir_q, dir_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [RW-1:0]          rail_q, rail_d, r_q, r_d;
  logic [D_WIDTH-1:0]     data_q, data_d;
  logic                   valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic [D_WIDTH-1:0]     buf_q [MAX_NOF_CHARS];
  logic [D_WIDTH-1:0]     buf_d [MAX_NOF_CHARS];
  logic [CW-1:0]          len_q [MAX_KEY];
  logic [CW-1:0]          len_d [MAX_KEY];
  logic [CW-1:0]          ptr_q [MAX_KEY];
  logic [CW-1:0]          ptr_d [MAX_KEY];

  logic [RW-1:0]          last_rail, r_prev, rail_nxt;
  logic                   dir_nxt;

  assign last_rail = RW'(key_q - 1'b1);
  assign r_prev    = r_q - 1'b1;

  // Zigzag walk: bounce off rail K-1 going down and off rail 0 going up; a single rail never moves.
  always_comb begin
    rail_nxt = rail_q;
    dir_nxt  = dir_q;
    if (last_rail != '0) begin
      if (!dir_q) begin
        if (rail_q == last_rail) begin
          rail_nxt = rail_q - 1'b1;
          dir_nxt  = 1'b1;
        end else begin
          rail_nxt = rail_q + 1'b1;
        end
      end else if (rail_q == '0) begin
        rail_nxt = rail_q + 1'b1;
        dir_nxt  = 1'b0;
      end else begin
        rail_nxt = rail_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    key_d   = key_q;
    p_d     = p_q;
    rail_d  = rail_q;
    dir_d   = dir_q;
    r_d     = r_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    buf_d   = buf_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    case (state_q)
      LOAD: begin
        if (valid_i) begin
          if (data_i == START_DECRYPTION_TOKEN) begin
            if (n_q != '0) begin
              if (key == '0 || key > MAX_K || ovf_q) begin
                err_d = 1'b1;
                n_d   = '0;
                ovf_d = 1'b0;
              end else begin
                key_d   = key;
                state_d = COUNT;
                busy_d  = 1'b1;
                p_d     = '0;
                rail_d  = '0;
                dir_d   = 1'b0;
              end
            end
          end else if (n_q < MAX_N) begin
            buf_d[n_q] = data_i;
            n_d        = n_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      COUNT: begin
        len_d[rail_q] = len_q[rail_q] + 1'b1;
        p_d    = p_q + 1'b1;
        rail_d = rail_nxt;
        dir_d  = dir_nxt;
        if (p_q == n_q - 1'b1) begin
          state_d = OFFS;
          r_d     = '0;
        end
      end
      OFFS: begin
        if (r_q == '0) ptr_d[0] = '0;
        else           ptr_d[r_q] = ptr_q[r_prev] + len_q[r_prev];
        r_d = r_q + 1'b1;
        if (r_q == last_rail) begin
          state_d = OUT;
          p_d     = '0;
          rail_d  = '0;
          dir_d   = 1'b0;
        end
      end
      OUT: begin
        // One extra pass after the last beat keeps busy high through the final valid_o cycle.
        if (p_q == n_q) begin
          busy_d  = 1'b0;
          n_d     = '0;
          state_d = LOAD;
          for (int i = 0; i < MAX_KEY; i++) len_d[i] = '0;
        end else begin
          data_d        = buf_q[ptr_q[rail_q]];
          ptr_d[rail_q] = ptr_q[rail_q] + 1'b1;
          valid_d       = 1'b1;
          p_d           = p_q + 1'b1;
          rail_d        = rail_nxt;
          dir_d         = dir_nxt;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      key_q   <= '0;
      p_q     <= '0;
      rail_q  <= '0;
      dir_q   <= 1'b0;
      r_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_KEY; i++) begin
        len_q[i] <= '0;
        ptr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      key_q   <= key_d;
      p_q     <= p_d;
      rail_q  <= rail_d;
      dir_q   <= dir_d;
      r_q     <= r_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_zigzag_decryption_n.sv
// tb/tb_zigzag_decryption_n.sv - directed self-checking bench for zigzag_decryption_n
module tb_zigzag_decryption_n;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;
  logic       err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap [$];
  int         first_c;
  int         busy_bad;

  localparam string ALPHA  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  localparam string PLAIN50 = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwx";

  zigzag_decryption_n dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key     (key),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference rail-fence encryption, rail(i) from the closed-form period 2K-2.
  function automatic string zz_encrypt(input string p, input int k);
    string c;
    int    per, m, rr;
    c = "";
    per = (k == 1) ? 1 : 2 * k - 2;
    for (int r = 0; r < k; r++) begin
      for (int i = 0; i < p.len(); i++) begin
        m  = i % per;
        rr = (m < k) ? m : per - m;
        if (rr == r) c = {c, p.substr(i, i)};
      end
    end
    return c;
  endfunction

  function automatic int cap_diff(input string e);
    int d;
    d = 0;
    if (cap.size() != e.len()) d++;
    for (int i = 0; i < e.len() && i < cap.size(); i++)
      if (cap[i] !== e[i]) d++;
    return d;
  endfunction

  // Sends characters then the token; returns at the negedge of cycle T+1+junk.
  task automatic send_msg(input string s, input int k, input int junk);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      data_i  = s[i];
      valid_i = 1'b1;
    end
    @(negedge clk);
    data_i  = 8'hFA;
    key     = k[7:0];
    valid_i = 1'b1;
    @(negedge clk);
    for (int j = 0; j < junk; j++) begin
      data_i = (j == junk - 1) ? 8'hFA : 8'h51;
      key    = 8'd3;
      @(negedge clk);
    end
    valid_i = 1'b0;
    key     = 8'd0;
  endtask

  // Captures output beats; cycle numbers are relative to the token edge T.
  task automatic capture(input int start);
    int cyc;
    bit done;
    cap.delete();
    first_c  = -1;
    busy_bad = 0;
    done     = 1'b0;
    cyc      = start;
    while (!done && cyc < 400) begin
      if (valid_o === 1'b1) begin
        if (first_c < 0) first_c = cyc;
        cap.push_back(data_o);
        if (busy !== 1'b1) busy_bad++;
      end else if (cap.size() > 0) begin
        done = 1'b1;
        if (busy !== 1'b0) busy_bad++;
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) busy_bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; key = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset data_o: got %h need 00", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset valid_o: got %b need 0", valid_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b need 0", busy); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset err_o: got %b need 0", err_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_decrypt(input string name, input string ct, input int k, input string pt, input int junk);
    int d;
    send_msg(ct, k, junk);
    capture(1 + junk);
    d = cap_diff(pt);
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL %s plaintext: %0d beats with %0d differences, need %0d beats of %s", name, cap.size(), d, pt.len(), pt); end
    n_cmp++; if (first_c != ct.len() + k + 2) begin n_bad++; $display("FAIL %s latency: first valid_o at T+%0d need T+%0d", name, first_c, ct.len() + k + 2); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL %s busy: %0d bad busy cycles need 0", name, busy_bad); end
  endtask

  task automatic test_bad_key(input int k);
    int stray;
    send_msg("ABC", k, 0);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL badkey%0d err_o at T+1: got %b need 1", k, err_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badkey%0d busy at T+1: got %b need 0", k, busy); end
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL badkey%0d err_o at T+2: got %b need 0", k, err_o); end
    stray = 0;
    repeat (12) begin
      if (valid_o !== 1'b0 || busy !== 1'b0 || err_o !== 1'b0) stray++;
      @(negedge clk);
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL badkey%0d quiet: %0d active cycles need 0", k, stray); end
  endtask

  task automatic test_overflow();
    string s;
    int    stray;
    s = "";
    for (int i = 0; i < 51; i++) s = {s, ALPHA.substr(i % 26, i % 26)};
    send_msg(s, 2, 0);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL overflow err_o at T+1: got %b need 1", err_o); end
    stray = 0;
    @(negedge clk);
    repeat (60) begin
      if (valid_o !== 1'b0 || busy !== 1'b0 || err_o !== 1'b0) stray++;
      @(negedge clk);
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL overflow quiet: %0d active cycles need 0", stray); end
    test_decrypt("full50", zz_encrypt(PLAIN50, 5), 5, PLAIN50, 0);
  endtask

  task automatic test_empty_token();
    int stray;
    send_msg("", 2, 0);
    stray = 0;
    repeat (8) begin
      if (valid_o !== 1'b0 || busy !== 1'b0 || err_o !== 1'b0) stray++;
      @(negedge clk);
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL empty_token: %0d active cycles need 0", stray); end
  endtask

  task automatic test_reset_mid();
    int beats, cyc;
    send_msg("HLOEL", 2, 0);
    beats = 0;
    cyc   = 0;
    while (beats < 3 && cyc < 100) begin
      if (valid_o === 1'b1) beats++;
      if (beats < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++; if (beats != 3) begin n_bad++; $display("FAIL reset_mid beats seen: got %0d need 3", beats); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_mid valid_o: got %b need 0", valid_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy: got %b need 0", busy); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_mid data_o: got %h need 00", data_o); end
    rst_n = 1'b1;
    test_decrypt("after_reset", "HLOEL", 2, "HELLO", 0);
  endtask

  task automatic test_busy_ignored();
    test_decrypt("busy_junk", "HLOEL", 2, "HELLO", 3);
    test_decrypt("after_junk", "XYZ", 1, "XYZ", 0);
  endtask

  task automatic test_back_to_back();
    int d;
    send_msg("HLOEL", 2, 0);
    capture(1);
    data_i  = "H";
    valid_i = 1'b1;
    send_msg("LOEL", 2, 0);
    capture(1);
    d = cap_diff("HELLO");
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL back_to_back plaintext: %0d beats with %0d differences, need HELLO", cap.size(), d); end
    n_cmp++; if (first_c != 9) begin n_bad++; $display("FAIL back_to_back latency: got T+%0d need T+9", first_c); end
  endtask

  initial begin
    test_reset();
    test_decrypt("key3", "WECRLTEERDSOEEFEAOCAIVDEN", 3, "WEAREDISCOVEREDFLEEATONCE", 0);
    test_decrypt("key2", "HLOEL", 2, "HELLO", 0);
    test_decrypt("key4", "AGBFHCED", 4, "ABCDEFGH", 0);
    test_decrypt("key1", "XYZ", 1, "XYZ", 0);
    test_bad_key(0);
    test_bad_key(9);
    test_decrypt("after_badkey", "HLOEL", 2, "HELLO", 0);
    test_overflow();
    test_decrypt("key_gt_n", "AB", 7, "AB", 0);
    test_empty_token();
    test_reset_mid();
    test_busy_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zigzag_decryption_n.md
# zigzag_decryption_n

Parametrised N-rail zigzag (rail-fence) decryption engine. It buffers a ciphertext stream until the start token arrives, then emits the plaintext one character per cycle. It generalises the fixed 2/3-rail decryptor to any key from 1 to MAX_KEY, and adds explicit error reporting for bad keys and buffer overflow. It sits in the cipher datapath alongside the other decryption blocks, fed by the same byte-stream interface.

## Interface
- D_WIDTH, 8, character width
- KEY_WIDTH, 8, key port width
- MAX_NOF_CHARS, 50, buffer depth in characters
- MAX_KEY, 8, largest supported rail count
- START_DECRYPTION_TOKEN, 8'hFA, end-of-ciphertext / start-of-decryption marker
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- data_i  in  D_WIDTH  ciphertext character
- valid_i  in  1  data_i qualifier
- key  in  KEY_WIDTH  rail count; sampled on the token cycle
- data_o  out  D_WIDTH  plaintext character
- valid_o  out  1  data_o qualifier
- busy  out  1  high while the engine processes a message; input ignored
- err_o  out  1  one-cycle pulse on a rejected message

## Operation
- Reset values: data_o=0, valid_o=0, busy=0, err_o=0, state LOAD, char count N=0, overflow flag clear.
- LOAD: each valid_i with a non-token character is written to buf[N], then N++.
  - When N == MAX_NOF_CHARS, further characters are dropped and the overflow flag is set.
- Token with valid_i in LOAD:
  - If N == 0: ignored, stay in LOAD.
  - Else if key == 0, key > MAX_KEY, or overflow is set: err_o pulses, the buffer is discarded (N=0, flag cleared), stay in LOAD, no output.
  - Else: latch key_q=key and go to COUNT.
- COUNT (N cycles): sweep p = 0..N-1.
  - rail(p) follows the zigzag 0,1,…,K-1,K-2,…,1,0,…; if K == 1, rail is always 0.
  - len[rail(p)]++ each cycle.
- OFFS (K cycles): ptr[0]=0, then ptr[r]=ptr[r-1]+len[r-1], one rail per cycle.
- OUT (N cycles): for p = 0..N-1:
  - data_o <= buf[ptr[rail(p)]], then ptr[rail(p)]++.
  - valid_o=1.
- After the last beat: valid_o=0, busy=0, len[] cleared, N=0, back to LOAD.
- Rails beyond N are empty when key > N; output is still correct.
- Pointer and count widths are $clog2(MAX_NOF_CHARS+1) bits. Rail counter is $clog2(MAX_KEY) bits, with a direction bit for the zigzag.
- valid_i while busy=1 is ignored, including tokens.

## Timing
- Token sampled at edge T.
- busy=1 from cycle T+1 through the last valid_o cycle, inclusive.
- First valid_o in cycle T+N+K+2.
- Exactly N consecutive valid_o cycles, no gaps.
- busy=0 in the cycle after the final beat. A character presented in that cycle is accepted.
- err_o is high for exactly cycle T+1; busy stays 0 on error.
- Synchronous reset mid-message (any state) restores all reset values at the next edge. Any partially emitted output is abandoned; valid_o=0 the following cycle.
- key changes after the token cycle have no effect on the message in flight.

## Test plan
- key=3, input "WECRLTEERDSOEEFEAOCAIVDEN"+FA -> 25 beats "WEAREDISCOVEREDFLEEATONCE"; first valid_o at T+30.
- key=2, "HLOEL"+FA -> "HELLO"; key=4, "AGBFHCED"+FA -> "ABCDEFGH"; key=1, "XYZ"+FA -> "XYZ".
- key=0 and key=MAX_KEY+1 with "ABC"+FA -> err_o single pulse at T+1, no valid_o, busy stays 0; next message with key=2 decrypts correctly.
- 51 characters then FA -> err_o pulse, no output. Then 50 characters with key=5 -> 50 correct beats.
- key=7, "AB"+FA (key > N) -> "AB". FA with empty buffer -> no busy, no err_o.
- Reset asserted during the 3rd OUT beat -> outputs at reset values next cycle. A fresh "HLOEL"+FA with key=2 -> "HELLO". Characters sent while busy do not appear in the next message.
